// File: rtl/face_detect_udiv_22ns_7ns_16_seq.sv
// Sequential radix-2 restoring unsigned divider (22-bit / 7-bit -> 16-bit quotient,
// 7-bit remainder). One quotient bit is produced per enabled clock edge.
//
// Handshake: an operand pair is taken on an edge where in_valid & in_ready (in_ready
// already includes ce). A result is offered with out_valid held high and outputs
// frozen until an edge where out_valid & out_ready & ce. All state, including the
// FSM, only advances on edges where ce is high.
module face_detect_udiv_22ns_7ns_16_seq #(
    parameter int DIVIDEND_W = 22,
    parameter int DIVISOR_W  = 7,
    parameter int QUOTIENT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf,
    output logic                  dbz,
    output logic [1:0]            dbg_state_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIVISOR_W-1:0]    dsr_q;
    // Holds the unconsumed dividend bits at the top and the quotient bits
    // collected so far at the bottom; after the last iteration it is the full quotient.
    logic [DIVIDEND_W-1:0]   quo_q;
    logic [DIVISOR_W-1:0]    rem_q;
    logic [QUOTIENT_W-1:0]   res_quo_q;
    logic [DIVISOR_W-1:0]    res_rem_q;
    logic                    ovf_q;
    logic                    dbz_q;

    logic                    accept;
    logic                    last_iter;
    logic [DIVISOR_W:0]      rem_shift;
    logic                    quo_bit;
    logic [DIVISOR_W-1:0]    rem_next;
    logic [DIVIDEND_W-1:0]   quo_next;
    logic                    hi_set;

    // State register: frozen while ce is low, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero divisor skips the iteration phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (divisor != '0) ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle and enabled; valid for the whole DONE state.
    always_comb begin
        in_ready    = (state_q == S_IDLE) && ce;
        out_valid   = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // rem_q is always below the divisor, so the shifted value fits DIVISOR_W+1 bits
    // and the difference fits back into DIVISOR_W bits.
    always_comb begin
        accept    = in_valid && in_ready;
        last_iter = (cnt_q == CNT_W'(DIVIDEND_W - 1));
        rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
        quo_bit   = (rem_shift >= {1'b0, dsr_q});
        rem_next  = quo_bit ? DIVISOR_W'(rem_shift - {1'b0, dsr_q})
                            : rem_shift[DIVISOR_W-1:0];
        quo_next  = {quo_q[DIVIDEND_W-2:0], quo_bit};
        hi_set    = ((quo_next >> QUOTIENT_W) != '0);
    end

    // Datapath: operand capture, iteration, and result registers held through DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            res_quo_q <= '0;
            res_rem_q <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        dsr_q <= divisor;
                        quo_q <= dividend;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            res_quo_q <= '1;
                            res_rem_q <= '0;
                            ovf_q     <= 1'b0;
                            dbz_q     <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    quo_q <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        // Saturate rather than wrap when the true quotient is too wide.
                        res_quo_q <= hi_set ? '1 : quo_next[QUOTIENT_W-1:0];
                        res_rem_q <= rem_next;
                        ovf_q     <= hi_set;
                        dbz_q     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result ports come straight from the held result registers.
    always_comb begin
        quotient  = res_quo_q;
        remainder = res_rem_q;
        ovf       = ovf_q;
        dbz       = dbz_q;
    end

endmodule

// File: tb/tb_face_detect_udiv_22ns_7ns_16_seq.sv
// Directed bench for the sequential 22/7 divider: reset values, results with
// hand-computed quotients/remainders, overflow and divide-by-zero corners,
// back-pressure, ce stalls and reset in the middle of an operation.
module tb_face_detect_udiv_22ns_7ns_16_seq;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] dividend;
    logic [6:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [6:0]  remainder;
    logic        ovf;
    logic        dbz;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    face_detect_udiv_22ns_7ns_16_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .ovf        (ovf),
        .dbz        (dbz),
        .dbg_state_o(dbg_state)
    );

    // Clock: 10 ns period; inputs change and outputs are sampled 1 ns after each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single edge (block must be idle with ce high),
    // then park junk on the operand bus to show it is not sampled again.
    task automatic issue(input logic [21:0] dvd, input logic [6:0] dsr);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        tick();
        in_valid = 1'b0;
        dividend = 22'h155555;
        divisor  = 7'd5;
    endtask

    // Count edges after the acceptance edge until out_valid is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Consume the held result with ce high.
    task automatic consume(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s consume out_valid got %b want 0", name, out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s consume in_ready got %b want 1", name, in_ready); end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        checks++; if (quotient !== 16'h0) begin failures++; $display("FAIL reset quotient got %h want 0000", quotient); end
        checks++; if (remainder !== 7'h0) begin failures++; $display("FAIL reset remainder got %h want 00", remainder); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset ovf got %b want 0", ovf); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset dbz got %b want 0", dbz); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset state got %0d want 0", dbg_state); end
        reset_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        ce = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready_ce0 got %b want 0", in_ready); end
        ce = 1'b1;
        #1;
    endtask

    // Generic divide: latency 22 and hand-computed results.
    task automatic test_divide(input string name, input logic [21:0] dvd, input logic [6:0] dsr,
                               input logic [15:0] eq, input logic [6:0] er, input logic eo);
        int lat;
        issue(dvd, dsr);
        wait_done(lat);
        checks++; if (lat != 22) begin failures++; $display("FAIL %s latency got %0d want 22", name, lat); end
        checks++; if (quotient !== eq) begin failures++; $display("FAIL %s quotient got %h want %h", name, quotient, eq); end
        checks++; if (remainder !== er) begin failures++; $display("FAIL %s remainder got %0d want %0d", name, remainder, er); end
        checks++; if (ovf !== eo) begin failures++; $display("FAIL %s ovf got %b want %b", name, ovf, eo); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL %s dbz got %b want 0", name, dbz); end
        consume(name);
    endtask

    // Zero divisor: DONE straight from the acceptance edge, visible before the next edge.
    task automatic test_dbz();
        int lat;
        issue(22'd50, 7'd0);
        wait_done(lat);
        checks++; if (lat != 0) begin failures++; $display("FAIL dbz latency got %0d want 0", lat); end
        checks++; if (quotient !== 16'hFFFF) begin failures++; $display("FAIL dbz quotient got %h want ffff", quotient); end
        checks++; if (remainder !== 7'd0) begin failures++; $display("FAIL dbz remainder got %0d want 0", remainder); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz flag got %b want 1", dbz); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL dbz ovf got %b want 0", ovf); end
        consume("dbz");
    endtask

    // 1000/9 = 111 r 1, with a competing in_valid during CALC and a stalled consumer.
    task automatic test_backpressure();
        int lat;
        issue(22'd1000, 7'd9);
        in_valid = 1'b1;
        dividend = 22'd77;
        divisor  = 7'd3;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp calc in_ready got %b want 0", in_ready); end
        wait_done(lat);
        in_valid = 1'b0;
        checks++; if (lat != 22) begin failures++; $display("FAIL bp latency got %0d want 22", lat); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp hold%0d out_valid got %b want 1", i, out_valid); end
            checks++; if (quotient !== 16'd111) begin failures++; $display("FAIL bp hold%0d quotient got %0d want 111", i, quotient); end
            checks++; if (remainder !== 7'd1) begin failures++; $display("FAIL bp hold%0d remainder got %0d want 1", i, remainder); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp hold%0d in_ready got %b want 0", i, in_ready); end
        end
        ce = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp ce0 out_valid got %b want 1", out_valid); end
        ce = 1'b1;
        out_ready = 1'b0;
        consume("bp");
    endtask

    // ce low for 3 cycles mid-CALC: latency 25, result unchanged (100/7 = 14 r 2).
    task automatic test_ce_stall();
        int lat;
        issue(22'd100, 7'd7);
        repeat (5) tick();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL stall%0d state got %0d want 1", i, dbg_state); end
        end
        ce = 1'b1;
        wait_done(lat);
        lat += 8;
        checks++; if (lat != 25) begin failures++; $display("FAIL stall latency got %0d want 25", lat); end
        checks++; if (quotient !== 16'd14) begin failures++; $display("FAIL stall quotient got %0d want 14", quotient); end
        checks++; if (remainder !== 7'd2) begin failures++; $display("FAIL stall remainder got %0d want 2", remainder); end
        consume("stall");
    endtask

    // Reset at iteration 10 and again while a result is held; then 9/3 = 3 r 0.
    task automatic test_reset_mid();
        int lat;
        issue(22'd1000, 7'd7);
        repeat (10) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_calc out_valid got %b want 0", out_valid); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_calc state got %0d want 0", dbg_state); end
        tick();
        reset_n = 1'b1;
        issue(22'd1000, 7'd7);
        wait_done(lat);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_done pre out_valid got %b want 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_done out_valid got %b want 0", out_valid); end
        checks++; if (quotient !== 16'h0) begin failures++; $display("FAIL rst_done quotient got %h want 0000", quotient); end
        tick();
        reset_n = 1'b1;
        test_divide("after_rst", 22'd9, 7'd3, 16'd3, 7'd0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_divide("basic", 22'd100, 7'd7, 16'd14, 7'd2, 1'b0);
        test_divide("max", 22'h3FFFFF, 7'd127, 16'h8102, 7'd1, 1'b0);
        test_dbz();
        test_divide("ovf_edge", 22'd65535, 7'd1, 16'hFFFF, 7'd0, 1'b0);
        test_divide("ovf", 22'd65536, 7'd1, 16'hFFFF, 7'd0, 1'b1);
        test_divide("ovf_rem", 22'd200000, 7'd3, 16'hFFFF, 7'd2, 1'b1);
        test_backpressure();
        test_ce_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
